cnn_layer_seq: RTL

Multi-layer sequencer for the CNN accelerator core. It sits between the CNN control-register block and the core. It holds a small table of per-layer base addresses and, on a rising edge of the control block's `enable`, issues one start pulse per layer with that layer's base address. It waits for the core's per-layer done before starting the next layer, then raises a sticky sequence-done flag that the control block reports through its status register.

---
 rtl/cnn_seq_pkg.sv | 22 ++
 rtl/cnn_layer_seq_if.sv | 28 ++
 rtl/cnn_seq_watchdog.sv | 41 ++++
 rtl/cnn_layer_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cnn_seq_pkg.sv
// cnn_seq_pkg: shared types and default sizes for the CNN multi-layer sequencer.
//   seq_state_e  - sequencer FSM states
//   desc_word_t  - descriptor table word (layer base address)
package cnn_seq_pkg;

    localparam int unsigned MAX_LAYERS_DEF = 8;
    localparam int unsigned TO_W_DEF       = 16;
    localparam int unsigned DESC_W         = 32;

    typedef logic [DESC_W-1:0] desc_word_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        NEXT,
        DONE,
        ERR
    } seq_state_e;

endpackage

// File: rtl/cnn_layer_seq_if.sv
// cnn_layer_seq_if: sequencer <-> CNN core layer handshake.
//   layer_start - one-cycle start pulse to the core
//   layer_idx   - index of the current layer
//   layer_base  - base address of the current layer
//   layer_done  - per-layer completion from the core (pulse or level)
// Modports: master = sequencer side, slave = core side.
interface cnn_layer_seq_if #(
    parameter int unsigned IDX_W = 3
);
    logic                   layer_start;
    logic [IDX_W-1:0]       layer_idx;
    cnn_seq_pkg::desc_word_t layer_base;
    logic                   layer_done;

    modport master (
        output layer_start,
        output layer_idx,
        output layer_base,
        input  layer_done
    );

    modport slave (
        input  layer_start,
        input  layer_idx,
        input  layer_base,
        output layer_done
    );
endinterface

// File: rtl/cnn_seq_watchdog.sv
// cnn_seq_watchdog: per-layer wait watchdog, built only with CNN_SEQ_TIMEOUT_EN.
//   clk, rst - clock, synchronous active-high reset
//   clr      - hold the count at zero (asserted outside WAIT)
//   cnt_en   - count this cycle (asserted in WAIT)
//   limit    - expiry limit in WAIT cycles; 0 disables
//   expire   - this WAIT cycle is the limit-th one
module cnn_seq_watchdog #(
    parameter int unsigned TO_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            cnt_en,
    input  logic [TO_W-1:0] limit,
    output logic            expire
);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    // cnt_d is the number of WAIT cycles elapsed including the current one
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_en) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    assign expire = cnt_en & ~clr & (limit != '0) & (cnt_d == limit);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cnn_layer_seq.sv
// cnn_layer_seq: multi-layer sequencer between the CNN control block and the core.
// On a rising edge of enable it issues one start pulse per layer with that layer's
// base address from a small descriptor table, waiting for layer_done between layers,
// then sets the sticky seq_done flag.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   enable          - launch on 0->1 transition
//   abort           - synchronous return to IDLE
//   num_layers      - layer count (0..MAX_LAYERS, larger values clamp), sampled at launch
//   desc_we/waddr/wdata - descriptor table write port
//   timeout_cycles  - per-layer watchdog limit, 0 disables
//   core            - layer handshake (layer_start/idx/base out, layer_done in)
//   seq_busy        - high outside IDLE
//   seq_done        - sticky sequence-complete flag
//   seq_err         - sticky watchdog-expired flag
// Build option: define CNN_SEQ_TIMEOUT_EN to include the per-layer watchdog;
// otherwise seq_err is tied low and timeout_cycles is unused.
module cnn_layer_seq
    import cnn_seq_pkg::*;
#(
    parameter  int unsigned MAX_LAYERS = MAX_LAYERS_DEF,
    parameter  int unsigned TO_W       = TO_W_DEF,
    localparam int unsigned IDX_W      = $clog2(MAX_LAYERS),
    localparam int unsigned CNT_W      = IDX_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_layers,
    input  logic             desc_we,
    input  logic [IDX_W-1:0] desc_waddr,
    input  desc_word_t       desc_wdata,
    input  logic [TO_W-1:0]  timeout_cycles,
    cnn_layer_seq_if.master  core,
    output logic             seq_busy,
    output logic             seq_done,
    output logic             seq_err
);

    seq_state_e       state_q, state_d;
    logic             enable_q;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] count_q, count_d;
    desc_word_t       base_q, base_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    desc_word_t       desc_tab_q [MAX_LAYERS];

    logic             launch_c;
    logic             last_c;
    logic [CNT_W-1:0] num_clamped_c;
    logic             wd_expire;

    assign launch_c      = enable & ~enable_q;
    assign num_clamped_c = (num_layers > CNT_W'(MAX_LAYERS)) ? CNT_W'(MAX_LAYERS) : num_layers;
    assign last_c        = ((CNT_W'(idx_q) + CNT_W'(1)) == count_q);

`ifdef CNN_SEQ_TIMEOUT_EN
    logic err_q, err_d;

    cnn_seq_watchdog #(
        .TO_W (TO_W)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q != WAIT),
        .cnt_en (state_q == WAIT),
        .limit  (timeout_cycles),
        .expire (wd_expire)
    );
`else
    logic unused_timeout;

    assign wd_expire      = 1'b0;
    assign unused_timeout = ^timeout_cycles;
`endif

    // Next-state and next-output logic; outputs are registered from the next state
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        base_d  = base_q;
        done_d  = done_q;
`ifdef CNN_SEQ_TIMEOUT_EN
        err_d   = err_q;
`endif
        if (abort) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (launch_c) begin
                        done_d  = 1'b0;
`ifdef CNN_SEQ_TIMEOUT_EN
                        err_d   = 1'b0;
`endif
                        count_d = num_clamped_c;
                        idx_d   = '0;
                        state_d = (num_clamped_c == '0) ? DONE : LOAD;
                    end
                end
                LOAD: begin
                    // Reads the pre-write table contents, so a same-cycle write is not seen
                    base_d  = desc_tab_q[idx_q];
                    state_d = START;
                end
                START: state_d = WAIT;
                WAIT: begin
                    // layer_done wins over a simultaneous watchdog expiry
                    if (core.layer_done) begin
                        state_d = NEXT;
                    end else if (wd_expire) begin
                        state_d = ERR;
                    end
                end
                NEXT: begin
                    if (last_c) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = LOAD;
                    end
                end
                DONE: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                ERR: begin
`ifdef CNN_SEQ_TIMEOUT_EN
                    err_d   = 1'b1;
`endif
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        start_d = (state_d == START);
        busy_d  = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            enable_q <= 1'b0;
            idx_q    <= '0;
            count_q  <= '0;
            base_q   <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef CNN_SEQ_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            enable_q <= enable;
            idx_q    <= idx_d;
            count_q  <= count_d;
            base_q   <= base_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef CNN_SEQ_TIMEOUT_EN
            err_q    <= err_d;
`endif
        end
    end

    // Descriptor table: not reset, writable in every state
    always_ff @(posedge clk) begin
        if (desc_we) begin
            desc_tab_q[desc_waddr] <= desc_wdata;
        end
    end

    assign core.layer_start = start_q;
    assign core.layer_idx   = idx_q;
    assign core.layer_base  = base_q;
    assign seq_busy         = busy_q;
    assign seq_done         = done_q;
`ifdef CNN_SEQ_TIMEOUT_EN
    assign seq_err          = err_q;
`else
    assign seq_err          = 1'b0;
`endif

endmodule
